// File: rtl/spi_shift_reg.sv
// SPI master shift engine: drives MOSI, samples MISO, assembles rx word.
// Optional LSB-first ordering via SPI_LSB_FIRST_EN (adds i_lsb port).
module spi_shift_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_char_len,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_negedge,
  input  logic              i_rx_negedge,
`ifdef SPI_LSB_FIRST_EN
  input  logic              i_lsb,
`endif
  input  logic              i_pos_edge,
  input  logic              i_neg_edge,
  input  logic              i_miso,
  output logic              o_mosi,
  output logic              o_busy,
  output logic              o_last_clk,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0]  MAXL = CNT_W'(DATA_W);
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                txneg_q, txneg_d;
  logic                rxneg_q, rxneg_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [CNT_W-1:0]    s_q, s_d;
  logic                mosi_q, mosi_d;
  logic [DATA_W-1:0]   rxd_q, rxd_d;

  logic [CNT_W-1:0]    len_in;
  logic                lsb_new, lsb_cur;
  logic                rx_stb, tx_stb;
  logic [CNT_W-1:0]    s_n, rk;
  logic [DATA_W-1:0]   rx_n;

`ifdef SPI_LSB_FIRST_EN
  logic lsb_q, lsb_d;
  assign lsb_new = i_lsb;
  assign lsb_cur = lsb_q;
`else
  assign lsb_new = 1'b0;
  assign lsb_cur = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] idx(
    input logic [CNT_W-1:0] len,
    input logic [CNT_W-1:0] k,
    input logic             lsb
  );
    return lsb ? k : len - k - CNT_W'(1);
  endfunction

  function automatic logic bit_at(
    input logic [DATA_W-1:0] w,
    input logic [CNT_W-1:0]  i
  );
    return |(w & (ONE << i));
  endfunction

  assign len_in = (i_char_len == '0 || i_char_len > MAXL)
                ? MAXL : i_char_len;

  // Next-state: latch on start, sample-then-drive per strobe, finish on last sample
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    tx_d    = tx_q;
    txneg_d = txneg_q;
    rxneg_d = rxneg_q;
    rx_d    = rx_q;
    s_d     = s_q;
    mosi_d  = mosi_q;
    rxd_d   = rxd_q;
`ifdef SPI_LSB_FIRST_EN
    lsb_d   = lsb_q;
`endif
    rx_stb  = 1'b0;
    tx_stb  = 1'b0;
    s_n     = s_q;
    rk      = '0;
    rx_n    = rx_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = SHIFT;
          len_d   = len_in;
          tx_d    = i_tx_data;
          txneg_d = i_tx_negedge;
          rxneg_d = i_rx_negedge;
`ifdef SPI_LSB_FIRST_EN
          lsb_d   = i_lsb;
`endif
          rx_d    = '0;
          s_d     = '0;
          mosi_d  = bit_at(i_tx_data, idx(len_in, '0, lsb_new));
        end
      end
      SHIFT: begin
        rx_stb = rxneg_q ? i_neg_edge : i_pos_edge;
        tx_stb = txneg_q ? i_neg_edge : i_pos_edge;
        if (rx_stb) begin
          rk   = idx(len_q, s_q, lsb_cur);
          rx_n = (rx_q & ~(ONE << rk)) | (DATA_W'(i_miso) << rk);
          s_n  = s_q + CNT_W'(1);
        end
        if (tx_stb && s_n != len_q) begin
          mosi_d = bit_at(tx_q, idx(len_q, s_n, lsb_cur));
        end
        rx_d = rx_n;
        s_d  = s_n;
        if (rx_stb && s_n == len_q) begin
          state_d = DONE;
          rxd_d   = rx_n;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transfer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      tx_q    <= '0;
      txneg_q <= 1'b0;
      rxneg_q <= 1'b0;
      rx_q    <= '0;
      s_q     <= '0;
      mosi_q  <= 1'b0;
      rxd_q   <= '0;
`ifdef SPI_LSB_FIRST_EN
      lsb_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      tx_q    <= tx_d;
      txneg_q <= txneg_d;
      rxneg_q <= rxneg_d;
      rx_q    <= rx_d;
      s_q     <= s_d;
      mosi_q  <= mosi_d;
      rxd_q   <= rxd_d;
`ifdef SPI_LSB_FIRST_EN
      lsb_q   <= lsb_d;
`endif
    end
  end

  assign o_mosi     = mosi_q;
  assign o_busy     = (state_q == SHIFT);
  assign o_done     = (state_q == DONE);
  assign o_last_clk = (state_q == SHIFT) && (s_q == len_q - CNT_W'(1));
  assign o_rx_data  = rxd_q;

endmodule

// File: tb/tb_spi_shift_reg.sv
// Bench for spi_shift_reg: vector table of transfers plus reset-abort case.
// Received words go through a scoreboard queue checked on o_done.
module tb_spi_shift_reg;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [5:0]  i_char_len = '0;
  logic [31:0] i_tx_data = '0;
  logic        i_tx_negedge = 1'b0;
  logic        i_rx_negedge = 1'b0;
`ifdef SPI_LSB_FIRST_EN
  logic        lsb_r = 1'b0;
`endif
  logic        i_pos_edge = 1'b0;
  logic        i_neg_edge = 1'b0;
  logic        miso_r = 1'b0;
  logic        loop_en = 1'b0;
  wire         i_miso;
  logic        o_mosi, o_busy, o_last_clk, o_done;
  logic [31:0] o_rx_data;

  assign i_miso = loop_en ? o_mosi : miso_r;

  spi_shift_reg #(.DATA_W(32), .CNT_W(6)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_char_len(i_char_len),
    .i_tx_data(i_tx_data),
    .i_tx_negedge(i_tx_negedge),
    .i_rx_negedge(i_rx_negedge),
`ifdef SPI_LSB_FIRST_EN
    .i_lsb(lsb_r),
`endif
    .i_pos_edge(i_pos_edge),
    .i_neg_edge(i_neg_edge),
    .i_miso(i_miso),
    .o_mosi(o_mosi),
    .o_busy(o_busy),
    .o_last_clk(o_last_clk),
    .o_rx_data(o_rx_data),
    .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [5:0]  len;
    logic [31:0] tx;
    logic [31:0] miso;
    logic        txneg;
    logic        rxneg;
    logic        lsb;
    logic        loop;
    logic        simul;
    logic        noise;
    logic [31:0] exp_rx;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  logic [31:0] sb_e;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          done_cnt = 0;

  int          t_L, t_k, t_nb, t_lcerr;
  logic        t_lsb, t_rxneg;
  logic [31:0] t_cap, t_word;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && o_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected_done actual=%0h required=none",
                 o_rx_data);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_rx_data", 64'(o_rx_data), 64'(sb_e));
      end
    end
  end

  task automatic lc_check();
    if (o_last_clk !== (o_busy && (t_k == t_L - 1))) t_lcerr++;
  endtask

  task automatic strobe(input logic p, input logic n);
    logic rx;
    int   bi;
    rx = t_rxneg ? n : p;
    i_pos_edge = p;
    i_neg_edge = n;
    if (rx && t_k < t_L) begin
      if (o_busy) t_nb++;
      bi = t_lsb ? t_k : t_L - 1 - t_k;
      t_cap[bi] = o_mosi;
    end
    @(negedge i_clk);
    i_pos_edge = 1'b0;
    i_neg_edge = 1'b0;
    if (rx && t_k < t_L) begin
      t_k++;
      if (t_k < t_L) miso_r = t_word[t_lsb ? t_k : t_L - 1 - t_k];
    end
    lc_check();
    @(negedge i_clk);
    lc_check();
  endtask

  task automatic xfer(input vec_t v, input int abort_after);
    logic [31:0] mask;
    logic        pre;
    int          done0;
    t_L = (v.len == 0 || v.len > 32) ? 32 : int'(v.len);
    mask = (t_L == 32) ? 32'hFFFF_FFFF : ((32'd1 << t_L) - 1);
    t_k = 0; t_nb = 0; t_lcerr = 0; t_cap = '0;
    t_lsb = v.lsb; t_rxneg = v.rxneg; t_word = v.miso;
    miso_r = v.miso[v.lsb ? 0 : t_L - 1];
    pre = v.tx[v.lsb ? 0 : t_L - 1];
    loop_en = v.loop;
    i_char_len = v.len;
    i_tx_data = v.tx;
    i_tx_negedge = v.txneg;
    i_rx_negedge = v.rxneg;
`ifdef SPI_LSB_FIRST_EN
    lsb_r = v.lsb;
`endif
    done0 = done_cnt;
    if (abort_after < 0) exp_q.push_back(v.exp_rx);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("busy_after_start", 64'(o_busy), 64'd1);
    chk("mosi_preload", 64'(o_mosi), 64'(pre));
    for (int b = 0; b < t_L; b++) begin
      if (abort_after >= 0 && t_k == abort_after) begin
        #3 i_rst_n = 1'b0;
        #1;
        chk("abort_outs", {o_rx_data, 28'd0, o_mosi, o_busy,
                           o_last_clk, o_done}, 64'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("abort_no_done", 64'(done_cnt), 64'(done0));
        i_rst_n = 1'b1;
        @(negedge i_clk);
        return;
      end
      if (v.noise && b == 3) begin
        i_start = 1'b1;
        i_tx_data = ~v.tx;
        @(negedge i_clk);
        i_start = 1'b0;
      end
      if (v.simul) strobe(1'b1, 1'b1);
      else begin
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b1);
      end
    end
    repeat (4) @(negedge i_clk);
    chk("done_pulses", 64'(done_cnt - done0), 64'd1);
    chk("mosi_seq", 64'(t_cap & mask), 64'(v.tx & mask));
    chk("busy_rx_strobes", 64'(t_nb), 64'(t_L));
    chk("last_clk_window", 64'(t_lcerr), 64'd0);
    chk("idle_after", {62'd0, o_busy, o_done}, 64'd0);
    chk("rx_hold", 64'(o_rx_data), 64'(v.exp_rx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{6'd8,  32'h0000_00A5, 32'h0, 1, 0, 0, 1, 0, 0,
                    32'h0000_00A5});
    tbl.push_back('{6'd0,  32'hDEAD_BEEF, 32'h1234_5678, 0, 1, 0, 0, 0, 0,
                    32'h1234_5678});
    tbl.push_back('{6'd4,  32'h0000_0003, 32'h0, 1, 0, 0, 1, 0, 0,
                    32'h0000_0003});
    tbl.push_back('{6'd12, 32'h0000_0ABC, 32'h0000_05F0, 1, 0, 0, 0, 0, 0,
                    32'h0000_05F0});
    tbl.push_back('{6'd1,  32'h0000_0001, 32'h0, 0, 1, 0, 1, 0, 0,
                    32'h0000_0001});
    tbl.push_back('{6'd40, 32'h0F0F_1234, 32'h0, 1, 0, 0, 1, 0, 1,
                    32'h0F0F_1234});
    tbl.push_back('{6'd2,  32'h0000_0002, 32'h0, 0, 0, 0, 1, 1, 0,
                    32'h0000_0002});
    tbl.push_back('{6'd5,  32'h0000_001F, 32'h0000_000A, 1, 1, 0, 0, 0, 0,
                    32'h0000_000A});
`ifdef SPI_LSB_FIRST_EN
    tbl.push_back('{6'd4,  32'h0000_0003, 32'h0, 1, 0, 1, 1, 0, 0,
                    32'h0000_0003});
    tbl.push_back('{6'd8,  32'h0000_0096, 32'h0000_0035, 0, 1, 1, 0, 0, 0,
                    32'h0000_0035});
`endif
    repeat (3) @(negedge i_clk);
    chk("reset_outs", {o_rx_data, 28'd0, o_mosi, o_busy,
                       o_last_clk, o_done}, 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("idle_outs", {o_rx_data, 28'd0, o_mosi, o_busy,
                      o_last_clk, o_done}, 64'd0);
    foreach (tbl[i]) xfer(tbl[i], -1);
    xfer(tbl[0], 3);
    xfer(tbl[0], -1);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_shift_reg.md
# spi_shift_reg

Serial data path of the universal SPI master: a transmit/receive shift engine that consumes the `o_pos_edge`/`o_neg_edge` strobes of `spi_clk_gen` and drives MOSI. It samples MISO and assembles the received word. It also returns `o_busy` and `o_last_clk` to the clock generator's `i_enable` and `i_last_clk` inputs. It is a single `i_clk` domain; all edge strobes are one-`i_clk`-wide pulses.

## Interface
- `DATA_W`, default 32: maximum character length in bits.
- `CNT_W`, default 6: bit-counter width; must be at least clog2(`DATA_W`)+1.
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  transfer request pulse; accepted only in IDLE.
- `i_char_len`  in  `CNT_W`  bits per transfer; 0 or any value above `DATA_W` means `DATA_W`.
- `i_tx_data`  in  `DATA_W`  word to send; the low `len` bits are used.
- `i_tx_negedge`  in  1  1 = drive MOSI on neg-edge strobe; 0 = on pos-edge strobe.
- `i_rx_negedge`  in  1  1 = sample MISO on neg-edge strobe; 0 = on pos-edge strobe.
- `i_lsb`  in  1  1 = LSB first; present only with `SPI_LSB_FIRST_EN`.
- `i_pos_edge`, `i_neg_edge`  in  1  edge strobes from `spi_clk_gen`.
- `i_miso`  in  1  serial input.
- `o_mosi`  out  1  serial output, registered.
- `o_busy`  out  1  high in SHIFT; connects to the clock generator's enable.
- `o_last_clk`  out  1  last bit pending; connects to the clock generator's `i_last_clk`.
- `o_rx_data`  out  `DATA_W`  received word, right-aligned, upper bits 0.
- `o_done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SHIFT, DONE. Reset enters IDLE. All outputs reset to 0.
- **IDLE → SHIFT on `i_start`:**
  - Latch `len`, `i_tx_data`, the two edge selects and `i_lsb`. Changes to these inputs during a transfer have no effect.
  - Clear the internal rx register and the sample count `s` to 0.
  - Preload `o_mosi` with bit index `idx(0)`.
- Bit index: `idx(k)` = `len`-1-`k` for MSB first, `k` for LSB first.
- **rx strobe (selected edge) in SHIFT:** write `i_miso` to rx bit `idx(s)`, then `s`++.
- **tx strobe (selected edge) in SHIFT:** `o_mosi` ← tx bit `idx(s)`, using the post-increment `s` when an rx strobe occurs in the same cycle.
  - This single rule covers both phase modes. When the tx edge comes first, the first tx strobe re-drives bit 0.
  - A tx strobe with `s` = `len` is ignored.
- `o_last_clk` = SHIFT and `s` == `len`-1 (combinational from registers).
- **SHIFT → DONE** on the rx strobe that makes `s` == `len`. In that cycle `o_rx_data` is loaded from the completed rx register.
- **DONE:** `o_done` = 1, `o_busy` = 0, then unconditional transition to IDLE. An `i_start` in DONE is ignored.
- Edge strobes outside SHIFT are ignored.
- `o_mosi` holds its last value after a transfer until the next `i_start`.
- If `i_tx_negedge` == `i_rx_negedge`, sample and drive happen on the same strobe, following the ordering above. No error is flagged.
- If `i_pos_edge` and `i_neg_edge` arrive in the same cycle, both are processed, sample first, then drive.
- An asynchronous reset mid-transfer aborts immediately: IDLE, all outputs 0, no `o_done`.

## Timing
- `i_start` to `o_busy` = 1: 1 cycle, registered.
- `o_mosi` preload is visible 1 cycle after `i_start`.
- Sample or drive takes effect 1 cycle after the strobe cycle.
- Final rx strobe to `o_done` = 1, `o_busy` = 0 and `o_rx_data` valid: 1 cycle.
- `o_rx_data` is stable from DONE until the next completion.
- Back-to-back transfers: the earliest next `i_start` is accepted in the cycle after DONE (IDLE).
- Throughput is bounded by the strobe rate. There is no internal wait state between bits.

## Configuration
- `SPI_LSB_FIRST_EN`:
  - Defined: the `i_lsb` port exists and selects bit order per transfer, latched at `i_start`.
  - Undefined: the port is absent and transfers are always MSB first. No LSB-order logic is synthesised.

## Test plan
- **8-bit MSB first, tx neg / rx pos, MISO looped to MOSI.** Send 0xA5 → `o_rx_data` = 0x000000A5, exactly one `o_done`, `o_busy` high for exactly 8 rx strobes.
- **`i_char_len` = 0, tx pos / rx neg, `i_tx_data` = 0xDEADBEEF, MISO fed 0x12345678 MSB first.** → MOSI bit sequence equals 0xDEADBEEF MSB first; `o_rx_data` = 0x12345678; `o_last_clk` high only between the 31st and 32nd samples.
- **`SPI_LSB_FIRST_EN` defined, `i_lsb` = 1, len 4, tx 0x3.** → MOSI sequence 1,1,0,0; with MISO looped, `o_rx_data` = 0x3.
- **len 40 on `DATA_W` = 32.** → clamped to 32 samples; `i_start` pulses and `i_tx_data` changes mid-transfer are ignored; the result matches the data latched at `i_start`.
- **Reset asserted after 3 of 8 bits.** → all outputs 0 immediately, no `o_done`; a fresh 8-bit transfer afterwards completes correctly.
- **Simultaneous `i_pos_edge` and `i_neg_edge` with tx and rx on the same edge, len 2.** → each strobe samples bit `s`, then drives bit `s`+1; `o_rx_data` equals the looped data.
